// File: rtl/mem_port_arb.sv
// Two-requester arbiter for a single RAM data port: the core normally owns the port,
// and a serial loader gets either idle cycles or a bounded burst after STARVE_LIM core grants.
module mem_port_arb #(
    parameter int STARVE_LIM = 8,
    parameter int LDR_BURST  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic [31:0] core_addr,
    input  logic [3:0]  core_wren,
    input  logic [31:0] core_din,
    output logic        core_stall,
    output logic        core_rvalid,
    input  logic        ldr_req,
    input  logic [31:0] ldr_addr,
    input  logic [3:0]  ldr_wren,
    input  logic [31:0] ldr_din,
    output logic        ldr_ack,
    output logic        ldr_rvalid,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wren,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    typedef enum logic {CORE_OWN, LDR_OWN} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_CORE, TAG_LDR} tag_t;

    localparam logic [8:0] STARVE_LIM_W = 9'(STARVE_LIM);
    localparam logic [8:0] LDR_BURST_W  = 9'(LDR_BURST);

    state_t     state_q, state_d;
    tag_t       tag_q, tag_d;
    logic [7:0] core_cnt_q, core_cnt_d;
    logic [7:0] ldr_cnt_q, ldr_cnt_d;
    logic [8:0] core_cnt_inc, ldr_cnt_inc;
    logic       core_grant, ldr_grant;

    assign core_cnt_inc = {1'b0, core_cnt_q} + 9'd1;
    assign ldr_cnt_inc  = {1'b0, ldr_cnt_q} + 9'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CORE_OWN;
            tag_q      <= TAG_NONE;
            core_cnt_q <= '0;
            ldr_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            core_cnt_q <= core_cnt_d;
            ldr_cnt_q  <= ldr_cnt_d;
        end
    end

    // Give-away loader grants in CORE_OWN fall through untouched: no state or counter change.
    always_comb begin
        state_d    = state_q;
        core_cnt_d = core_cnt_q;
        ldr_cnt_d  = ldr_cnt_q;
        tag_d      = TAG_NONE;
        if (core_grant && core_wren == 4'b0000) begin
            tag_d = TAG_CORE;
        end else if (ldr_grant && ldr_wren == 4'b0000) begin
            tag_d = TAG_LDR;
        end
        case (state_q)
            CORE_OWN: begin
                ldr_cnt_d = '0;
                if (!ldr_req) begin
                    core_cnt_d = '0;
                end else if (core_grant) begin
                    if (core_cnt_inc >= STARVE_LIM_W) begin
                        state_d    = LDR_OWN;
                        core_cnt_d = '0;
                    end else begin
                        core_cnt_d = core_cnt_inc[7:0];
                    end
                end
            end
            LDR_OWN: begin
                core_cnt_d = '0;
                if (!ldr_req || ldr_cnt_inc >= LDR_BURST_W) begin
                    state_d   = CORE_OWN;
                    ldr_cnt_d = '0;
                end else begin
                    ldr_cnt_d = ldr_cnt_inc[7:0];
                end
            end
        endcase
    end

    always_comb begin
        core_grant = 1'b0;
        ldr_grant  = 1'b0;
        case (state_q)
            CORE_OWN: begin
                core_grant = core_req;
                ldr_grant  = !core_req && ldr_req;
            end
            LDR_OWN: begin
                ldr_grant  = ldr_req;
                core_grant = !ldr_req && core_req;
            end
        endcase
        mem_addr = '0;
        mem_wren = 4'b0000;
        mem_din  = '0;
        if (core_grant) begin
            mem_addr = core_addr;
            mem_wren = core_wren;
            mem_din  = core_din;
        end else if (ldr_grant) begin
            mem_addr = ldr_addr;
            mem_wren = ldr_wren;
            mem_din  = ldr_din;
        end
        core_stall  = core_req && !core_grant;
        ldr_ack     = ldr_grant;
        core_rvalid = (tag_q == TAG_CORE);
        ldr_rvalid  = (tag_q == TAG_LDR);
        rdata       = mem_dout;
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: a default-parameter instance backed by a small RAM model,
// plus a STARVE_LIM=1/LDR_BURST=1 instance sharing the same request inputs.
module tb_mem_port_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, ldr_req;
    logic [31:0] core_addr, ldr_addr, core_din, ldr_din;
    logic [3:0]  core_wren, ldr_wren;

    logic        core_stall, core_rvalid, ldr_ack, ldr_rvalid;
    logic [31:0] rdata, mem_addr, mem_din, mem_dout;
    logic [3:0]  mem_wren;

    logic        a_core_stall, a_core_rvalid, a_ldr_ack, a_ldr_rvalid;
    logic [31:0] a_rdata, a_mem_addr, a_mem_din;
    logic [3:0]  a_mem_wren;
    logic [31:0] a_mem_dout = 32'h0;

    logic [31:0] ram [0:127];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mem_port_arb dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_addr(core_addr), .core_wren(core_wren), .core_din(core_din),
        .core_stall(core_stall), .core_rvalid(core_rvalid),
        .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wren(ldr_wren), .ldr_din(ldr_din),
        .ldr_ack(ldr_ack), .ldr_rvalid(ldr_rvalid), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    mem_port_arb #(.STARVE_LIM(1), .LDR_BURST(1)) dut_alt (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_addr(core_addr), .core_wren(core_wren), .core_din(core_din),
        .core_stall(a_core_stall), .core_rvalid(a_core_rvalid),
        .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wren(ldr_wren), .ldr_din(ldr_din),
        .ldr_ack(a_ldr_ack), .ldr_rvalid(a_ldr_rvalid), .rdata(a_rdata),
        .mem_addr(a_mem_addr), .mem_wren(a_mem_wren), .mem_din(a_mem_din), .mem_dout(a_mem_dout)
    );

    // RAM with one-cycle read latency and byte-lane writes, word-indexed by address[8:2].
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_wren[b]) ram[mem_addr[8:2]][8*b +: 8] <= mem_din[8*b +: 8];
        end
        mem_dout <= ram[mem_addr[8:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_core, prev_core, prev_ldr;
        for (int i = 0; i < 128; i++) ram[i] = 32'h1000_0000 + i;
        rst = 1'b1;
        core_req = 1'b1; core_addr = 32'h40; core_wren = 4'h0; core_din = 32'h0;
        ldr_req  = 1'b1; ldr_addr  = 32'h4;  ldr_wren  = 4'h0; ldr_din  = 32'h0;

        // Grants follow the CORE_OWN rules while reset is held.
        @(negedge clk);
        check("rst_core_stall", core_stall, 0);
        check("rst_ldr_ack", ldr_ack, 0);
        check("rst_mem_addr", mem_addr, 32'h40);
        check("rst_core_rvalid", core_rvalid, 0);
        check("rst_ldr_rvalid", ldr_rvalid, 0);
        next_cycle();
        rst = 1'b0; core_req = 1'b0; ldr_req = 1'b0;

        // Core-only back-to-back reads.
        core_req = 1'b1; core_addr = 32'h0;
        @(negedge clk);
        check("rd0_stall", core_stall, 0);
        check("rd0_rvalid", core_rvalid, 0);
        next_cycle(); core_addr = 32'h4;
        @(negedge clk);
        check("rd1_stall", core_stall, 0);
        check("rd1_rvalid", core_rvalid, 1);
        check("rd1_rdata", rdata, 32'h1000_0000);
        next_cycle(); core_addr = 32'h8;
        @(negedge clk);
        check("rd2_rvalid", core_rvalid, 1);
        check("rd2_rdata", rdata, 32'h1000_0001);
        next_cycle(); core_req = 1'b0;
        @(negedge clk);
        check("rd3_rvalid", core_rvalid, 1);
        check("rd3_rdata", rdata, 32'h1000_0002);
        next_cycle();
        @(negedge clk);
        check("rd4_rvalid", core_rvalid, 0);

        // Give-away loader write while the core is idle.
        next_cycle();
        ldr_req = 1'b1; ldr_addr = 32'h100; ldr_wren = 4'hF; ldr_din = 32'hDEAD_BEEF;
        @(negedge clk);
        check("ga_ack", ldr_ack, 1);
        check("ga_stall", core_stall, 0);
        check("ga_mem_wren", mem_wren, 4'hF);
        check("ga_mem_addr", mem_addr, 32'h100);
        check("ga_mem_din", mem_din, 32'hDEAD_BEEF);
        next_cycle();
        check("ga_core_cnt", dut.core_cnt_q, 0);
        core_req = 1'b1; core_addr = 32'h100;
        ldr_addr = 32'h4; ldr_wren = 4'h0; ldr_din = 32'h0;
        @(negedge clk);
        check("ga_still_core_stall", core_stall, 0);
        check("ga_still_core_ack", ldr_ack, 0);
        check("ga_wr_no_rvalid", ldr_rvalid, 0);
        next_cycle(); core_req = 1'b0; ldr_req = 1'b0; core_addr = 32'h0;
        @(negedge clk);
        check("wb_rvalid", core_rvalid, 1);
        check("wb_rdata", rdata, 32'hDEAD_BEEF);
        check("wb_core_cnt", dut.core_cnt_q, 1);
        next_cycle();
        check("idle_core_cnt", dut.core_cnt_q, 0);

        // Both requesting: 8 core grants then 4 loader grants, repeating.
        core_req = 1'b1; ldr_req = 1'b1;
        prev_core = 1'b0; prev_ldr = 1'b0;
        for (int c = 0; c < 24; c++) begin
            exp_core = (c % 12) < 8;
            @(negedge clk);
            check($sformatf("rr_stall_%0d", c), core_stall, !exp_core);
            check($sformatf("rr_ack_%0d", c), ldr_ack, !exp_core);
            check($sformatf("rr_crv_%0d", c), core_rvalid, prev_core);
            check($sformatf("rr_lrv_%0d", c), ldr_rvalid, prev_ldr);
            if (prev_core || prev_ldr)
                check($sformatf("rr_rdata_%0d", c), rdata, prev_core ? 32'h1000_0000 : 32'h1000_0001);
            prev_core = exp_core; prev_ldr = !exp_core;
            next_cycle();
        end

        // Enter LDR_OWN, take 2 loader grants, then the loader drops.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("lb_ack_%0d", c), ldr_ack, c >= 8);
            next_cycle();
        end
        ldr_req = 1'b0;
        @(negedge clk);
        check("ldrop_stall", core_stall, 0);
        check("ldrop_ack", ldr_ack, 0);
        next_cycle(); ldr_req = 1'b1;
        check("ldrop_ldr_cnt", dut.ldr_cnt_q, 0);
        @(negedge clk);
        check("back_core_stall", core_stall, 0);
        check("back_core_ack", ldr_ack, 0);
        next_cycle();

        // Seven more core grants reach the starvation limit; then reset mid-burst.
        repeat (7) next_cycle();
        @(negedge clk);
        check("burst_ack", ldr_ack, 1);
        check("burst_stall", core_stall, 1);
        next_cycle();
        check("burst_ldr_rvalid", ldr_rvalid, 1);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mrst_ldr_rvalid", ldr_rvalid, 0);
        check("mrst_core_rvalid", core_rvalid, 0);
        check("mrst_core_stall", core_stall, 0);
        check("mrst_ldr_ack", ldr_ack, 0);
        check("mrst_core_cnt", dut.core_cnt_q, 0);
        check("mrst_ldr_cnt", dut.ldr_cnt_q, 0);
        next_cycle();
        rst = 1'b0;

        // Minimum limits: strict core/loader alternation.
        for (int c = 0; c < 6; c++) begin
            exp_core = (c % 2) == 0;
            @(negedge clk);
            check($sformatf("alt_stall_%0d", c), a_core_stall, !exp_core);
            check($sformatf("alt_ack_%0d", c), a_ldr_ack, !exp_core);
            check($sformatf("alt_addr_%0d", c), a_mem_addr, exp_core ? 32'h0 : 32'h4);
            check($sformatf("alt_wren_%0d", c), a_mem_wren, 4'h0);
            check($sformatf("alt_din_%0d", c), a_mem_din, 32'h0);
            check($sformatf("alt_rdata_%0d", c), a_rdata, 32'h0);
            check($sformatf("alt_crv_%0d", c), a_core_rvalid, c > 0 && !exp_core);
            check($sformatf("alt_lrv_%0d", c), a_ldr_rvalid, c > 0 && exp_core);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 Parameter STARVE_LIM, default 8: maximum consecutive core grants while the loader waits; legal range 1..255.
REQ-002 Parameter LDR_BURST, default 4: maximum consecutive loader grants per loader turn; legal range 1..255.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 core_req  in  1  core requests a data-port access this cycle.
REQ-006 core_addr  in  32  core byte address.
REQ-007 core_wren  in  4  core byte-lane write enables; 4'b0000 means read.
REQ-008 core_din  in  32  core write data.
REQ-009 core_stall  out  1  core access not granted this cycle; core holds its request.
REQ-010 core_rvalid  out  1  read data for the core is on rdata this cycle.
REQ-011 ldr_req, ldr_addr, ldr_wren, ldr_din  in  1/32/4/32  serial-loader request, with the same meanings as the core request signals.
REQ-012 ldr_ack  out  1  loader access granted this cycle.
REQ-013 ldr_rvalid  out  1  read data for the loader is on rdata this cycle.
REQ-014 rdata  out  32  copy of mem_dout, shared by both requesters.
REQ-015 mem_addr, mem_wren, mem_din  out  32/4/32  RAM data port driven by the granted requester.
REQ-016 mem_dout  in  32  RAM read data, valid one cycle after the address is presented.

Function
REQ-017 The block SHALL implement two owner states: CORE_OWN and LDR_OWN.
REQ-018 In CORE_OWN: if core_req=1, grant the core; else if ldr_req=1, grant the loader as a give-away cycle; else grant nobody.
REQ-019 In LDR_OWN: if ldr_req=1, grant the loader; else if core_req=1, grant the core; else grant nobody.
REQ-020 Grants SHALL be combinational in the same cycle; at most one requester is granted per cycle.
REQ-021 core_stall = core_req AND NOT core_grant.
REQ-022 ldr_ack = ldr_grant.
REQ-023 mem_addr/mem_wren/mem_din SHALL mux from the granted requester; with no grant, mem_wren SHALL be 4'b0000 and mem_addr/mem_din SHALL be 0.
REQ-024 An 8-bit core_cnt SHALL increment on each CORE_OWN core grant that occurs while ldr_req=1.
REQ-025 core_cnt SHALL clear whenever ldr_req=0 or the state leaves CORE_OWN.
REQ-026 CORE_OWN -> LDR_OWN on the edge where core_cnt+1 reaches STARVE_LIM during a core grant with ldr_req=1.
REQ-027 A give-away loader grant in CORE_OWN SHALL neither change state nor modify core_cnt.
REQ-028 An 8-bit ldr_cnt SHALL increment on each loader grant in LDR_OWN.
REQ-029 LDR_OWN -> CORE_OWN, clearing ldr_cnt, when ldr_cnt+1 reaches LDR_BURST, or on any LDR_OWN cycle with ldr_req=0.
REQ-030 A registered read tag SHALL record which requester was granted a read (wren=0) in cycle t; in cycle t+1, exactly that requester's rvalid SHALL be 1.
REQ-031 Write grants SHALL produce no rvalid.
REQ-032 Back-to-back reads SHALL sustain one rvalid per cycle with no bubbles.
REQ-033 rdata SHALL equal mem_dout combinationally at all times.

Reset
REQ-034 On rst=1, asynchronously: state=CORE_OWN, core_cnt=0, ldr_cnt=0, read tag=none, core_rvalid=0, ldr_rvalid=0.
REQ-035 Combinational outputs SHALL follow REQ-018..023 from the reset state while rst=1.
REQ-036 Reset asserted mid-burst SHALL abandon the LDR_OWN turn; a pending rvalid SHALL be suppressed.
REQ-037 Operation after reset release SHALL begin on the first rising edge with rst=0.

Verification
REQ-038 Core-only reads at addresses 0x0, 0x4, 0x8 on consecutive cycles -> core_stall=0 throughout; core_rvalid=1 in each following cycle; rdata equals RAM contents.
REQ-039 core_req and ldr_req held at 1 continuously, defaults -> 8 core grants, 4 loader grants, repeating; core_stall=1 exactly during the loader grants.
REQ-040 core_req=0, ldr_req=1 write of 0xDEADBEEF to 0x100 with wren=4'hF -> ldr_ack=1 in the same cycle; mem_wren=4'hF; state stays CORE_OWN.
REQ-041 In LDR_OWN after 2 grants, ldr_req drops -> the next cycle returns to CORE_OWN with ldr_cnt=0 and serves the core without stalling.
REQ-042 rst pulsed while in LDR_OWN with a loader read outstanding -> ldr_rvalid=0 immediately; state returns to CORE_OWN; counters read 0.
REQ-043 STARVE_LIM=1, LDR_BURST=1, both requesting -> grants alternate core/loader every cycle.
